// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Purpose  : Parametrised inter-stage pipeline register with valid, carry
//            channel, last-action state and saturating stall-cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int                 DATA_W    = 64,
    parameter int                 CARRY_W   = 66,
    parameter int                 STALL_W   = 6,
    parameter int                 STAGE     = 3,
    parameter logic [DATA_W-1:0]  NOP_VALUE = {DATA_W{1'b0}},
    parameter int                 CNT_W     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [STALL_W-1:0]  stall,
    input  logic                flush,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [CARRY_W-1:0]  carry_i,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    output logic [CARRY_W-1:0]  carry_o,
    output logic [1:0]          stage_state,
    output logic [CNT_W-1:0]    stall_cnt
);

    localparam logic [1:0]       c_st_idle   = 2'b00;
    localparam logic [1:0]       c_st_run    = 2'b01;
    localparam logic [1:0]       c_st_bubble = 2'b10;
    localparam logic [1:0]       c_st_hold   = 2'b11;
    localparam logic [CNT_W-1:0] c_cnt_max   = {CNT_W{1'b1}};

    generate
        if (STAGE < 0 || STAGE > STALL_W - 2) begin : g_bad_stage
            $error("pipe_stage_reg: STAGE must lie in 0..STALL_W-2");
        end
    endgenerate

    logic               r_valid;
    logic [DATA_W-1:0]  r_data;
    logic [CARRY_W-1:0] r_carry;
    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_up_stall;
    logic               w_dn_stall;
    logic               w_valid_nxt;
    logic [DATA_W-1:0]  w_data_nxt;
    logic [CARRY_W-1:0] w_carry_nxt;
    logic [1:0]         w_state_nxt;

    assign w_up_stall = stall[STAGE];
    assign w_dn_stall = stall[STAGE+1];

    // Action priority below reset: flush > bubble > advance > hold.
    always_comb begin
        w_valid_nxt = r_valid;
        w_data_nxt  = r_data;
        w_carry_nxt = carry_i;
        w_state_nxt = c_st_hold;
        if (flush) begin
            w_valid_nxt = 1'b0;
            w_data_nxt  = NOP_VALUE;
            w_carry_nxt = '0;
            w_state_nxt = c_st_idle;
        end else if (w_up_stall && !w_dn_stall) begin
            w_valid_nxt = 1'b0;
            w_data_nxt  = NOP_VALUE;
            w_state_nxt = c_st_bubble;
        end else if (!w_up_stall) begin
            w_valid_nxt = in_valid;
            w_data_nxt  = in_valid ? in_data : NOP_VALUE;
            w_carry_nxt = '0;
            w_state_nxt = c_st_run;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= NOP_VALUE;
            r_carry <= '0;
            r_state <= c_st_idle;
        end else begin
            r_valid <= w_valid_nxt;
            r_data  <= w_data_nxt;
            r_carry <= w_carry_nxt;
            r_state <= w_state_nxt;
        end
    end

    // Counts upstream-stall cycles even while flushing; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_up_stall && (r_cnt != c_cnt_max)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign out_valid   = r_valid;
    assign out_data    = r_data;
    assign carry_o     = r_carry;
    assign stage_state = r_state;
    assign stall_cnt   = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_reg
// Purpose  : Directed self-checking bench for pipe_stage_reg.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic        in_valid;
    logic [63:0] in_data;
    logic [65:0] carry_i;

    logic        out_valid,  s_out_valid;
    logic [63:0] out_data,   s_out_data;
    logic [65:0] carry_o,    s_carry_o;
    logic [1:0]  stage_state, s_stage_state;
    logic [15:0] stall_cnt;
    logic [2:0]  s_stall_cnt;

    int checks   = 0;
    int failures = 0;

    localparam logic [65:0] c_carry = 66'h2_0000_0001_0000_0002;

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .carry_i(carry_i),
        .out_valid(out_valid), .out_data(out_data), .carry_o(carry_o),
        .stage_state(stage_state), .stall_cnt(stall_cnt)
    );

    pipe_stage_reg #(.CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .carry_i(carry_i),
        .out_valid(s_out_valid), .out_data(s_out_data), .carry_o(s_carry_o),
        .stage_state(s_stage_state), .stall_cnt(s_stall_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = '0; flush = 1'b0;
        in_valid = 1'b1; in_data = 64'hDEAD_BEEF; carry_i = c_carry;
        tick(); tick();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 64'h0 || carry_o !== 66'h0 ||
            stage_state !== 2'b00 || stall_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset: v=%b d=%h c=%h st=%b cnt=%0d, want 0/0/0/00/0",
                     out_valid, out_data, carry_o, stage_state, stall_cnt);
        end
        rst = 1'b0; carry_i = '0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 64'hDEAD_BEEF || stage_state !== 2'b01) begin
            failures++;
            $display("FAIL reset_release: v=%b d=%h st=%b, want 1/deadbeef/01",
                     out_valid, out_data, stage_state);
        end
    endtask

    task automatic test_bubble();
        stall = 6'b001000; carry_i = c_carry;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || out_data !== 64'h0 || carry_o !== c_carry ||
                stage_state !== 2'b10 || stall_cnt !== 16'(i)) begin
                failures++;
                $display("FAIL bubble[%0d]: v=%b d=%h c=%h st=%b cnt=%0d, want 0/0/%h/10/%0d",
                         i, out_valid, out_data, carry_o, stage_state, stall_cnt, c_carry, i);
            end
        end
        stall = '0;
        tick();
        checks++;
        if (carry_o !== 66'h0 || stage_state !== 2'b01 || out_data !== 64'hDEAD_BEEF ||
            stall_cnt !== 16'd3) begin
            failures++;
            $display("FAIL bubble_exit: c=%h st=%b d=%h cnt=%0d, want 0/01/deadbeef/3",
                     carry_o, stage_state, out_data, stall_cnt);
        end
    endtask

    task automatic test_hold();
        in_data = 64'h1234;
        tick();
        stall = 6'b011000;
        for (int i = 1; i <= 4; i++) begin
            in_data = 64'h5000 + 64'(i) * 64'h1111;
            tick();
            checks++;
            if (out_data !== 64'h1234 || out_valid !== 1'b1 || stage_state !== 2'b11 ||
                carry_o !== c_carry || stall_cnt !== 16'(3 + i)) begin
                failures++;
                $display("FAIL hold[%0d]: d=%h v=%b st=%b c=%h cnt=%0d, want 1234/1/11/%h/%0d",
                         i, out_data, out_valid, stage_state, carry_o, stall_cnt, c_carry, 3 + i);
            end
        end
    endtask

    task automatic test_flush();
        stall = 6'b011000; flush = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 64'h0 || carry_o !== 66'h0 ||
            stage_state !== 2'b00 || stall_cnt !== 16'd8) begin
            failures++;
            $display("FAIL flush: v=%b d=%h c=%h st=%b cnt=%0d, want 0/0/0/00/8",
                     out_valid, out_data, carry_o, stage_state, stall_cnt);
        end
        flush = 1'b0; stall = '0;
    endtask

    task automatic test_invalid();
        in_valid = 1'b0; in_data = 64'hFFFF;
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 64'h0 || stage_state !== 2'b01) begin
            failures++;
            $display("FAIL invalid_input: v=%b d=%h st=%b, want 0/0/01",
                     out_valid, out_data, stage_state);
        end
    endtask

    task automatic test_ignored_bits();
        stall = 6'b110111; in_valid = 1'b1; in_data = 64'hABCD;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 64'hABCD || stage_state !== 2'b01 ||
            carry_o !== 66'h0 || stall_cnt !== 16'd8) begin
            failures++;
            $display("FAIL ignored_bits: v=%b d=%h st=%b c=%h cnt=%0d, want 1/abcd/01/0/8",
                     out_valid, out_data, stage_state, carry_o, stall_cnt);
        end
        stall = '0;
    endtask

    task automatic test_saturation();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        stall = 6'b001000;
        for (int i = 1; i <= 10; i++) begin
            tick();
            checks++;
            if (s_stall_cnt !== 3'((i > 7) ? 7 : i) || stall_cnt !== 16'(i)) begin
                failures++;
                $display("FAIL saturation[%0d]: sat=%0d wide=%0d, want %0d/%0d",
                         i, s_stall_cnt, stall_cnt, (i > 7) ? 7 : i, i);
            end
        end
        stall = '0; rst = 1'b1;
        tick();
        checks++;
        if (s_stall_cnt !== 3'd0 || stall_cnt !== 16'd0 || carry_o !== 66'h0) begin
            failures++;
            $display("FAIL saturation_reset: sat=%0d wide=%0d c=%h, want 0/0/0",
                     s_stall_cnt, stall_cnt, carry_o);
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_bubble();
        test_hold();
        test_flush();
        test_invalid();
        test_ignored_bits();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Generic parametrised pipeline stage register for the OpenMIPS-style 5-stage core. It replaces the hand-written inter-stage latches (id_ex, ex_mem, mem_wb), each of which is an instance with its own parameters. It adds:
- configurable payload and carry-channel widths,
- a selectable stall-vector bit,
- a valid bit,
- a state register,
- a saturating stall-cycle counter.

The carry channel holds multi-cycle execute state (e.g. the madd/msub hilo accumulator and cycle count) across stalls.

Parameters:
DATA_W, 64, width of the forwarded payload (concatenated stage outputs)
CARRY_W, 66, width of the multi-cycle carry channel
STALL_W, 6, width of the stall vector from ctrl
STAGE, 3, index of the upstream stall bit; downstream bit is STAGE+1; legal range 0..STALL_W-2
NOP_VALUE, {DATA_W{1'b0}}, payload value driven for a bubble/flush/reset
CNT_W, 16, width of the stall-cycle counter

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  synchronous reset, active-high (rst==`RstEnable)
stall  in  STALL_W  stall vector from ctrl; 1=`Stop
flush  in  1  pipeline flush from ctrl (exception/eret)
in_valid  in  1  upstream stage holds a real instruction
in_data  in  DATA_W  upstream payload
carry_i  in  CARRY_W  multi-cycle state from upstream stage
out_valid  out  1  registered valid to downstream
out_data  out  DATA_W  registered payload to downstream
carry_o  out  CARRY_W  carry state fed back to upstream stage
stage_state  out  2  last action: 00 IDLE, 01 RUN, 10 BUBBLE, 11 HOLD
stall_cnt  out  CNT_W  saturating count of stalled cycles

Behaviour:
- All outputs are registers. Priority per rising edge is rst > flush > bubble > advance > hold.
- rst=1:
  - out_valid=0, out_data=NOP_VALUE, carry_o=0, stage_state=IDLE, stall_cnt=0.
  - Reset mid-operation discards any held payload and carry state immediately.
- flush=1 (rst=0):
  - out_valid=0, out_data=NOP_VALUE, carry_o=0, stage_state=IDLE.
  - stall_cnt is unaffected by the flush itself; it still increments if stall[STAGE]=1.
  - Flush overrides any stall combination.
- Bubble: stall[STAGE]=1 and stall[STAGE+1]=0.
  - out_valid=0, out_data=NOP_VALUE, carry_o=carry_i, stage_state=BUBBLE.
  - The downstream stage sees a NOP; the upstream multi-cycle state is preserved via carry.
- Advance: stall[STAGE]=0.
  - out_valid=in_valid.
  - out_data=in_data if in_valid=1, else NOP_VALUE.
  - carry_o=0, stage_state=RUN.
  - Advance applies even if stall[STAGE+1]=1; ctrl guarantees this never happens, and the block does not check for it.
- Hold: stall[STAGE]=1 and stall[STAGE+1]=1.
  - out_valid and out_data keep their previous values.
  - carry_o=carry_i, stage_state=HOLD.
- stall_cnt:
  - Increments by 1 on every non-reset cycle with stall[STAGE]=1, including flush cycles.
  - Saturates at 2^CNT_W-1 and never wraps.
  - Cleared only by rst.
- Latency: in_data appears on out_data one cycle after an advance edge.
- carry_o is zero in exactly the cycle after any advance, flush or reset edge.
- Stall bits outside STAGE and STAGE+1 are ignored.
- Illegal STAGE (> STALL_W-2) is an elaboration error; the implementation uses a generate-time $error.

Test Plan:
- Reset: rst=1 for 2 cycles with in_data=64'hDEAD_BEEF, in_valid=1, stall=0 -> out_valid=0, out_data=0, carry_o=0, stage_state=00, stall_cnt=0. Release with stall=0 -> next cycle out_data=64'hDEAD_BEEF, out_valid=1, stage_state=01.
- Bubble/carry: STAGE=3, stall=6'b001000 for 3 cycles, carry_i=66'h2_0000_0001_0000_0002 -> each cycle out_valid=0, out_data=0, carry_o=carry_i, stage_state=10, stall_cnt 1,2,3. Then stall=0 -> carry_o=0.
- Hold: preload out_data=64'h1234, then stall=6'b011000 for 4 cycles with in_data changing every cycle -> out_data stays 64'h1234, out_valid stays 1, stage_state=11, stall_cnt +4.
- Flush priority: stall=6'b011000 and flush=1 in the same cycle -> out_valid=0, out_data=0, carry_o=0, stage_state=00, stall_cnt still incremented.
- Saturation: CNT_W=3, stall[STAGE]=1 for 10 cycles -> stall_cnt reaches 7 and remains 7. Then rst=1 -> stall_cnt=0.
- Invalid input: stall=0, in_valid=0, in_data=64'hFFFF -> out_valid=0, out_data=NOP_VALUE, stage_state=01.
